wb_fifo_bridge: RTL and testbench
=================================

// Module: wb_fifo_bridge
// PURPOSE
//  Wishbone slave that sits directly downstream of the testbench Wishbone master (clk_i/rst_i domain).
//  It buffers master writes into a TX FIFO that drains onto a byte stream (valid/ready).
//  It buffers an incoming RX byte stream into an RX FIFO that the master pops by reading.
//  It raises irq_i-compatible interrupts for RX data and error events.
// PARAMETERS
//  ADDR_WIDTH  2  Wishbone address width. Must be >= 2. Only adr_i[1:0] is decoded.
//  DATA_WIDTH  8  Wishbone and stream data width.
//  FIFO_DEPTH  4  Entries per FIFO. Power of two, >= 2.
// PORTS
//  clk_i       in   1           System clock; all state changes on posedge.
//  rst_i       in   1           Reset, asynchronous, active-high.
//  cyc_i       in   1           Wishbone cycle.
//  stb_i       in   1           Wishbone strobe.
//  we_i        in   1           Wishbone write enable.
//  adr_i       in   ADDR_WIDTH  Register address.
//  dat_i       in   DATA_WIDTH  Write data.
//  dat_o       out  DATA_WIDTH  Read data; valid while ack_o=1.
//  ack_o       out  1           Wishbone acknowledge.
//  irq_o       out  1           Interrupt request to the master.
//  tx_data_o   out  DATA_WIDTH  TX stream data (head of TX FIFO).
//  tx_valid_o  out  1           TX stream valid.
//  tx_ready_i  in   1           TX stream ready.
//  rx_data_i   in   DATA_WIDTH  RX stream data.
//  rx_valid_i  in   1           RX stream valid.
//  rx_ready_o  out  1           RX stream ready.
// BEHAVIOUR
//  Reset values: ack_o=0, dat_o=0, irq_o=0, tx_valid_o=0, tx_data_o=0, rx_ready_o=0.
//   Both FIFOs are empty; CTRL=0; sticky flags=0.
//  Register map:
//   0 CTRL  rw: [7]=EN, [6]=IE, [1]=LOOP (see CONFIGURATION), [0]=FLUSH.
//     FLUSH is write-1 pulse and always reads 0.
//   1 STAT  ro: [0]=tx_full, [1]=tx_empty, [2]=rx_full, [3]=rx_empty.
//     [4]=tx_ovf (sticky), [5]=rx_udf (sticky). Writing 1 to bit 4/5 clears that bit.
//   2 TXD   write: push dat_i into TX FIFO. Read: returns TX count (zero-extended).
//   3 RXD   read: pop RX FIFO and return the byte. Write: ignored, still acked.
//  Handshake: the request is sampled at a posedge with cyc_i & stb_i & !ack_o.
//   ack_o goes 1 at that edge and returns to 0 at the next edge; no back-to-back acks.
//   Register side effects (push, pop, CTRL/STAT update) and dat_o occur at the same edge ack_o rises.
//   Latency is 1 clock. dat_o=0 when ack_o=0 or on any write.
//  TX push when tx_full (judged on pre-edge count): data dropped, tx_ovf=1.
//   A stream pop in the same cycle does not rescue the push; the pop still occurs.
//  RXD read when rx_empty (pre-edge count): dat_o=0x00, rx_udf=1.
//   A stream push in the same cycle still lands in the FIFO.
//  Stream side:
//   tx_valid_o = EN & !tx_empty; tx_data_o = head entry, or 0 when tx_valid_o=0.
//   rx_ready_o = EN & !rx_full.
//   A beat transfers at a posedge where valid & ready are both 1.
//  Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the count is unchanged.
//   Pointers wrap modulo FIFO_DEPTH; the count is held in a separate counter of width clog2(FIFO_DEPTH)+1.
//  EN=0: streams are stalled and FIFO contents are retained; Wishbone access works normally.
//  FLUSH: both FIFOs are emptied at that edge, overriding any same-cycle push or pop. Sticky flags are unchanged.
//  irq_o is registered: irq_o = IE & EN & (!rx_empty | tx_ovf | rx_udf), using post-edge state, 1 clock late.
//  Reset asserted mid-transfer: all state returns to reset values immediately; the pending request is not acked.
// CONFIGURATION
//  WB_FIFO_BRIDGE_LOOPBACK_EN defined:
//   When CTRL.LOOP=1, the TX FIFO head feeds the RX FIFO internally.
//   That beat transfers when EN & !tx_empty & !rx_full.
//   In loopback, tx_valid_o=0, rx_ready_o=0, and rx_*_i are ignored.
//  Macro undefined: CTRL[1] reads 0, writes to it are ignored, and no loopback logic is built.
// TESTING
//  1. Reset, read STAT -> 0x0A. Then write CTRL=0x80 and read it back -> 0x80; ack_o is high for exactly 1 clock per access.
//  2. EN=1, tx_ready_i=0, write TXD 0x11,0x22,0x33,0x44,0x55 -> TXD reads 4, STAT[0]=1, STAT[4]=1.
//     Then tx_ready_i=1 -> stream emits 11,22,33,44 in order and tx_valid_o drops.
//  3. EN=1, IE=1 (CTRL=0xC0), drive rx beats 0xA5,0x5A -> irq_o=1.
//     Two RXD reads return A5, 5A and irq_o falls. A third read returns 0x00, sets STAT[5], and irq_o=1.
//     Write STAT=0x20 -> irq_o=0.
//  4. FIFO at count 2, with a TXD write and tx_ready_i=1 on the same edge -> count stays 2 and order is preserved.
//     Repeat 2*FIFO_DEPTH times to cover pointer wrap.
//  5. FIFOs half full, write CTRL=0x81 -> both empty next cycle, sticky bits held.
//     Assert rst_i mid-access -> ack_o never rises.
//  6. With WB_FIFO_BRIDGE_LOOPBACK_EN, CTRL=0x82, write TXD 0x3C -> RXD read returns 0x3C and tx_valid_o stays 0.

Source files
------------

// File: rtl/wb_fifo_bridge.sv
// Wishbone slave bridging register accesses to a TX byte FIFO (drained onto a valid/ready
// stream) and an RX byte FIFO (filled from a valid/ready stream, popped by RXD reads).
// Latency: one clock per Wishbone access (ack_o and dat_o rise at the sampling edge).
// Backpressure: full TX push drops data and sets tx_ovf; rx_ready_o drops while RX is full
// or EN=0. Optional loopback of TX head into RX FIFO when WB_FIFO_BRIDGE_LOOPBACK_EN is defined.
//
// Ports: clk_i/rst_i (async active-high), cyc_i/stb_i/we_i/adr_i/dat_i/dat_o/ack_o Wishbone
// slave, irq_o interrupt, tx_data_o/tx_valid_o/tx_ready_i TX stream, rx_data_i/rx_valid_i/
// rx_ready_o RX stream. DATA_WIDTH must be >= 8 (CTRL/STAT bit positions).
module wb_fifo_bridge #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic ctrl_en_q, ctrl_en_d, ctrl_ie_q, ctrl_ie_d;
    logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic ack_q, irq_q;
    logic [DATA_WIDTH-1:0] dat_q, dat_d, rdata;

    logic [1:0] adr;
    logic wb_req, wr_req, rd_req, flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic loop_mode, loop_beat;
    logic [DATA_WIDTH-1:0] tx_head, rx_push_dat;

    assign adr    = adr_i[1:0];
    assign wb_req = cyc_i & stb_i & ~ack_q;   // ack_q blocks back-to-back acks
    assign wr_req = wb_req & we_i;
    assign rd_req = wb_req & ~we_i;
    assign flush  = wr_req & (adr == 2'd0) & dat_i[0];

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_head  = tx_mem_q[tx_rd_ptr_q];

`ifdef WB_FIFO_BRIDGE_LOOPBACK_EN
    logic ctrl_loop_q, ctrl_loop_d;
    assign loop_mode = ctrl_loop_q;
    assign loop_beat = ctrl_loop_q & ctrl_en_q & ~tx_empty & ~rx_full;
    always_comb begin
        ctrl_loop_d = ctrl_loop_q;
        if (wr_req && adr == 2'd0) ctrl_loop_d = dat_i[1];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ctrl_loop_q <= 1'b0;
        else       ctrl_loop_q <= ctrl_loop_d;
    end
`else
    assign loop_mode = 1'b0;
    assign loop_beat = 1'b0;
`endif

    assign tx_valid_o = ctrl_en_q & ~loop_mode & ~tx_empty;
    assign tx_data_o  = tx_valid_o ? tx_head : '0;
    assign rx_ready_o = ctrl_en_q & ~loop_mode & ~rx_full;

    // Full/empty judged on pre-edge counts: a same-edge pop never rescues a push.
    assign tx_push     = wr_req & (adr == 2'd2) & ~tx_full;
    assign tx_pop      = (tx_valid_o & tx_ready_i) | loop_beat;
    assign rx_push     = (rx_valid_i & rx_ready_o) | loop_beat;
    assign rx_push_dat = loop_beat ? tx_head : rx_data_i;
    assign rx_pop      = rd_req & (adr == 2'd3) & ~rx_empty;

    always_comb begin
        rdata = '0;
        unique case (adr)
            2'd0: begin
                rdata[7] = ctrl_en_q;
                rdata[6] = ctrl_ie_q;
                rdata[1] = loop_mode;
            end
            2'd1: begin
                rdata[0] = tx_full;
                rdata[1] = tx_empty;
                rdata[2] = rx_full;
                rdata[3] = rx_empty;
                rdata[4] = tx_ovf_q;
                rdata[5] = rx_udf_q;
            end
            2'd2:    rdata[CW-1:0] = tx_cnt_q;
            default: rdata = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
        endcase
    end

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + PW'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + PW'(tx_pop);
        tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + PW'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + PW'(rx_pop);
        rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_cnt_d    = '0;
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_cnt_d    = '0;
        end

        ctrl_en_d = ctrl_en_q;
        ctrl_ie_d = ctrl_ie_q;
        if (wr_req && adr == 2'd0) begin
            ctrl_en_d = dat_i[7];
            ctrl_ie_d = dat_i[6];
        end

        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;
        if (wr_req && adr == 2'd1) begin
            if (dat_i[4]) tx_ovf_d = 1'b0;
            if (dat_i[5]) rx_udf_d = 1'b0;
        end
        if (wr_req && adr == 2'd2 && tx_full) tx_ovf_d = 1'b1;
        if (rd_req && adr == 2'd3 && rx_empty) rx_udf_d = 1'b1;

        dat_d = rd_req ? rdata : '0;
    end

    // Storage has no reset; validity is tracked by the counters alone.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= dat_i;
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_push_dat;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            ctrl_en_q   <= 1'b0;
            ctrl_ie_q   <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rx_udf_q    <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_ie_q   <= ctrl_ie_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_udf_q    <= rx_udf_d;
            ack_q       <= wb_req;
            dat_q       <= dat_d;
            // Sampled from the current (previous-edge) state, so irq_o trails it by one clock.
            irq_q       <= ctrl_ie_q & ctrl_en_q & (~rx_empty | tx_ovf_q | rx_udf_q);
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign irq_o = irq_q;
endmodule

// File: tb/tb_wb_fifo_bridge.sv
// Self-checking bench for wb_fifo_bridge: directed register table, multi-cycle corner
// sequences and a randomized phase, all compared every cycle against a queue-based model.
// Clock period 10; inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_wb_fifo_bridge;
    localparam int D = 4;
`ifdef WB_FIFO_BRIDGE_LOOPBACK_EN
    localparam bit LOOP_OK = 1'b1;
`else
    localparam bit LOOP_OK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_w, dat_r;
    logic ack, irq;
    logic [7:0] tx_data;
    logic tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic rx_valid, rx_ready;

    always #5 clk = ~clk;

    wb_fifo_bridge #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
        .dat_i(dat_w), .dat_o(dat_r), .ack_o(ack), .irq_o(irq),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready)
    );

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit m_en, m_ie, m_loop, m_ovf, m_udf, m_ack, m_irq;
    logic [7:0] m_dat;

    // Stream inputs held across cycles
    bit txr_g, rxv_g;
    logic [7:0] rxd_g;
    logic [7:0] tx_seen[$];
    logic [7:0] exp_tx[$];
    logic [7:0] last_dat;

    typedef struct {
        bit         w;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_en = 0; m_ie = 0; m_loop = 0; m_ovf = 0; m_udf = 0; m_ack = 0; m_irq = 0;
        m_dat = 8'h00;
    endtask

    function automatic bit irq_fn();
        return m_ie && m_en && (rxq.size() != 0 || m_ovf || m_udf);
    endfunction

    task automatic cycle(input bit c, input bit s, input bit w, input logic [1:0] a,
                         input logic [7:0] d);
        bit req, tvld, lb, f_pre, flush, tx_pop, rx_push;
        int tx_pre, rx_pre;
        logic [7:0] rd, stat, rx_byte, exp_td;
        cyc = c; stb = s; we = w; adr = a; dat_w = d;
        tx_ready = txr_g; rx_valid = rxv_g; rx_data = rxd_g;
        if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
        @(posedge clk);
        #1;
        // model update from pre-edge state
        req = c && s && !m_ack;
        f_pre = irq_fn();
        tx_pre = txq.size();
        rx_pre = rxq.size();
        tvld = m_en && !m_loop && tx_pre != 0;
        lb = m_loop && m_en && tx_pre != 0 && rx_pre < D;
        tx_pop = (tvld && txr_g) || lb;
        rx_push = (m_en && !m_loop && rx_pre < D && rxv_g) || lb;
        rx_byte = lb ? txq[0] : rxd_g;
        stat = {2'b00, m_udf, m_ovf, rx_pre == 0, rx_pre == D, tx_pre == 0, tx_pre == D};
        rd = 8'h00;
        flush = 0;
        if (req && !w) begin
            case (a)
                2'd0: rd = {m_en, m_ie, 4'b0000, m_loop, 1'b0};
                2'd1: rd = stat;
                2'd2: rd = 8'(tx_pre);
                default: begin
                    if (rx_pre != 0) rd = rxq[0];
                    else m_udf = 1;
                end
            endcase
        end
        if (tx_pop) void'(txq.pop_front());
        if (req && !w && a == 2'd3 && rx_pre != 0) void'(rxq.pop_front());
        if (rx_push) rxq.push_back(rx_byte);
        if (req && w) begin
            case (a)
                2'd0: begin
                    m_en = d[7]; m_ie = d[6]; m_loop = LOOP_OK && d[1]; flush = d[0];
                end
                2'd1: begin
                    if (d[4]) m_ovf = 0;
                    if (d[5]) m_udf = 0;
                end
                2'd2: begin
                    if (tx_pre == D) m_ovf = 1;
                    else txq.push_back(d);
                end
                default: ;
            endcase
        end
        if (flush) begin
            txq.delete();
            rxq.delete();
        end
        m_irq = f_pre;
        m_ack = req;
        m_dat = rd;
        // compare post-edge outputs
        tvld = m_en && !m_loop && txq.size() != 0;
        exp_td = 8'h00;
        if (tvld) exp_td = txq[0];
        chk("ack", ack, m_ack);
        chk("dat_o", dat_r, m_dat);
        chk("tx_valid", tx_valid, tvld);
        chk("tx_data", tx_data, exp_td);
        chk("rx_ready", rx_ready, m_en && !m_loop && rxq.size() < D);
        if (f_pre == irq_fn()) chk("irq", irq, m_irq);
        last_dat = dat_r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic wb(input bit w, input logic [1:0] a, input logic [7:0] d,
                      output logic [7:0] r);
        cycle(1, 1, w, a, d);
        r = last_dat;
        chk("ack_rise", ack, 1);
        cycle(0, 0, 0, 2'd0, 8'h00);
        chk("ack_drop", ack, 0);
    endtask

    initial begin
        logic [7:0] r;
        bit c, s, w;
        logic [1:0] a;
        logic [7:0] d;

        tbl[0] = '{0, 2'd1, 8'h00, 8'h0A, "stat_reset"};
        tbl[1] = '{0, 2'd0, 8'h00, 8'h00, "ctrl_reset"};
        tbl[2] = '{1, 2'd0, 8'h80, 8'h00, "ctrl_wr_dat0"};
        tbl[3] = '{0, 2'd0, 8'h00, 8'h80, "ctrl_rd"};
        tbl[4] = '{0, 2'd2, 8'h00, 8'h00, "txcnt_empty"};
        tbl[5] = '{0, 2'd3, 8'h00, 8'h00, "rxd_empty"};
        tbl[6] = '{0, 2'd1, 8'h00, 8'h2A, "stat_udf"};
        tbl[7] = '{1, 2'd1, 8'h20, 8'h00, "stat_clr"};
        tbl[8] = '{0, 2'd1, 8'h00, 8'h0A, "stat_after_clr"};

        rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        txr_g = 0; rxv_g = 0; rxd_g = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_r, 0);
        chk("rst_irq", irq, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_rxr", rx_ready, 0);
        rst = 0;

        // 1: register table
        foreach (tbl[i]) begin
            wb(tbl[i].w, tbl[i].a, tbl[i].d, r);
            chk(tbl[i].name, r, tbl[i].exp);
        end

        // 2: TX overflow then drain
        txr_g = 0;
        wb(1, 2'd2, 8'h11, r);
        wb(1, 2'd2, 8'h22, r);
        wb(1, 2'd2, 8'h33, r);
        wb(1, 2'd2, 8'h44, r);
        wb(1, 2'd2, 8'h55, r);
        wb(0, 2'd2, 8'h00, r); chk("txcnt_full", r, 8'h04);
        wb(0, 2'd1, 8'h00, r); chk("stat_ovf", r, 8'h19);
        tx_seen.delete();
        txr_g = 1;
        idle(8);
        txr_g = 0;
        chk("drain_n", tx_seen.size(), 4);
        for (int i = 0; i < 4 && i < tx_seen.size(); i++)
            chk("drain_byte", tx_seen[i], 8'h11 * (i + 1));
        chk("drain_txv", tx_valid, 0);
        wb(1, 2'd1, 8'h10, r);

        // 3: RX data and error interrupts
        wb(1, 2'd0, 8'hC0, r);
        rxv_g = 1; rxd_g = 8'hA5; idle(1);
        rxd_g = 8'h5A; idle(1);
        rxv_g = 0; idle(2);
        chk("irq_rx", irq, 1);
        wb(0, 2'd3, 8'h00, r); chk("rxd_a5", r, 8'hA5);
        wb(0, 2'd3, 8'h00, r); chk("rxd_5a", r, 8'h5A);
        idle(2);
        chk("irq_fall", irq, 0);
        wb(0, 2'd3, 8'h00, r); chk("rxd_udf", r, 8'h00);
        wb(0, 2'd1, 8'h00, r); chk("stat_udf2", r, 8'h2A);
        idle(1);
        chk("irq_udf", irq, 1);
        wb(1, 2'd1, 8'h20, r);
        idle(2);
        chk("irq_clr", irq, 0);

        // 4: simultaneous push/pop at count 2, across pointer wrap
        wb(1, 2'd0, 8'h80, r);
        exp_tx.delete();
        tx_seen.delete();
        wb(1, 2'd2, 8'h40, r); exp_tx.push_back(8'h40);
        wb(1, 2'd2, 8'h41, r); exp_tx.push_back(8'h41);
        for (int i = 0; i < 2 * D; i++) begin
            txr_g = 1;
            cycle(1, 1, 1, 2'd2, 8'h50 + 8'(i));
            exp_tx.push_back(8'h50 + 8'(i));
            txr_g = 0;
            idle(1);
            wb(0, 2'd2, 8'h00, r); chk("cnt_hold", r, 8'h02);
        end
        txr_g = 1;
        idle(6);
        txr_g = 0;
        chk("order_n", tx_seen.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
            chk("order_byte", tx_seen[i], exp_tx[i]);

        // 5: flush keeps sticky flags
        wb(0, 2'd3, 8'h00, r);
        wb(1, 2'd2, 8'h61, r);
        wb(1, 2'd2, 8'h62, r);
        rxv_g = 1; rxd_g = 8'h71; idle(1);
        rxd_g = 8'h72; idle(1);
        rxv_g = 0;
        wb(0, 2'd2, 8'h00, r); chk("half_tx", r, 8'h02);
        cycle(1, 1, 1, 2'd0, 8'h81);
        chk("flush_txv", tx_valid, 0);
        idle(1);
        wb(0, 2'd1, 8'h00, r); chk("stat_flush", r, 8'h2A);
        wb(0, 2'd0, 8'h00, r); chk("ctrl_noflush", r, 8'h80);
        wb(1, 2'd1, 8'h20, r);

        // reset during a pending access
        wb(1, 2'd2, 8'h77, r);
        cyc = 1; stb = 1; we = 0; adr = 2'd1;
        #3 rst = 1;
        @(posedge clk); #1;
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_txv", tx_valid, 0);
        @(posedge clk); #1;
        chk("rst_mid_ack2", ack, 0);
        rst = 0; cyc = 0; stb = 0;
        model_reset();
        idle(1);
        chk("rst_after_ack", ack, 0);
        wb(0, 2'd1, 8'h00, r); chk("stat_post_rst", r, 8'h0A);

        // 6: loopback, or LOOP bit ignored without it
`ifdef WB_FIFO_BRIDGE_LOOPBACK_EN
        wb(1, 2'd0, 8'h82, r);
        wb(1, 2'd2, 8'h3C, r);
        idle(2);
        chk("lb_txv", tx_valid, 0);
        chk("lb_rxr", rx_ready, 0);
        wb(0, 2'd3, 8'h00, r); chk("lb_rxd", r, 8'h3C);
        wb(1, 2'd0, 8'h80, r);
`else
        wb(1, 2'd0, 8'h82, r);
        wb(0, 2'd0, 8'h00, r); chk("loop_ignored", r, 8'h80);
`endif

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom % 4) != 0;
            s = ($urandom % 2) != 0;
            w = ($urandom % 2) != 0;
            a = 2'($urandom % 4);
            d = 8'($urandom);
            if (w && a == 2'd0) begin
                d[7] = ($urandom % 8) != 0;
                d[0] = ($urandom % 16) == 0;
            end
            txr_g = ($urandom % 2) != 0;
            rxv_g = ($urandom % 2) != 0;
            rxd_g = 8'($urandom);
            cycle(c, s, w, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
